// File: rtl/layer_stream_serializer_pkg.sv
// Shared definitions for the inter-layer vector serializer: emission-order
// encodings and the index-width helper.
package layer_stream_serializer_pkg;

  localparam bit ORDER_LSB_FIRST = 1'b0;
  localparam bit ORDER_MSB_FIRST = 1'b1;

  // Neuron index width; a single-neuron vector still gets a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/layer_stream_serializer_argmax.sv
// Running signed argmax over the beats of one vector; reports the winning
// neuron number one cycle after the final beat is accepted.
module layer_stream_serializer_argmax #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IDX_W      = 4
) (
  input  logic                  s_axi_aclk,
  input  logic                  reset,
  input  logic                  beat_valid,
  input  logic [DATA_WIDTH-1:0] beat_data,
  input  logic [IDX_W-1:0]      beat_index,
  input  logic                  beat_last,
  output logic                  max_valid,
  output logic [IDX_W-1:0]      max_index
);

  logic                         fresh_q;
  logic signed [DATA_WIDTH-1:0] best_val_q;
  logic [IDX_W-1:0]             best_idx_q;
  logic                         take_c;
  logic [IDX_W-1:0]             win_idx_c;

  // Strictly-greater replacement so ties keep the earlier emitted beat.
  always_comb begin
    take_c    = fresh_q || ($signed(beat_data) > best_val_q);
    win_idx_c = take_c ? beat_index : best_idx_q;
  end

  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      fresh_q    <= 1'b1;
      best_val_q <= '0;
      best_idx_q <= '0;
      max_valid  <= 1'b0;
      max_index  <= '0;
    end else begin
      max_valid <= 1'b0;
      if (beat_valid) begin
        if (take_c) begin
          best_val_q <= $signed(beat_data);
          best_idx_q <= beat_index;
        end
        fresh_q <= beat_last;
        if (beat_last) begin
          max_valid <= 1'b1;
          max_index <= win_idx_c;
        end
      end
    end
  end

endmodule

// File: rtl/layer_stream_serializer.sv
// Captures a packed neuron-output vector into a 2-deep buffer and streams it
// one neuron per beat with valid/ready backpressure and optional argmax.
module layer_stream_serializer
  import layer_stream_serializer_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 10,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter bit          MSB_FIRST   = ORDER_LSB_FIRST,
  parameter bit          EN_ARGMAX   = 1'b1,
  localparam int unsigned IDX_W      = idx_width(NUM_NEURONS)
) (
  input  logic                              s_axi_aclk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
  output logic                              in_ready,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [IDX_W-1:0]                  out_index,
  output logic                              out_last,
  output logic                              max_valid,
  output logic [IDX_W-1:0]                  max_index,
  output logic                              overflow
);

  localparam int unsigned VEC_W    = NUM_NEURONS * DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              occ_q, occ_d, occ_rem;
  logic                    rd_ptr_q, rd_ptr_d, wr_ptr_q;
  logic [VEC_W-1:0]        slot_q [2];
  logic [VEC_W-1:0]        head_vec;
  logic [IDX_W-1:0]        beat_d, nsel, cur_neuron;
  logic [DATA_WIDTH-1:0]   data_d;
  logic                    cap, adv, pop, drop;

  function automatic logic [IDX_W-1:0] neuron_of(input logic [IDX_W-1:0] beat);
    return (MSB_FIRST == ORDER_MSB_FIRST) ? LAST_IDX - beat : beat;
  endfunction

  // Next-state, buffer bookkeeping and next beat selection.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    beat_d   = out_index;
    cap      = in_valid && in_ready;
    drop     = in_valid && !in_ready;
    adv      = out_valid && out_ready;
    pop      = adv && out_last;
    if (adv) beat_d = out_last ? '0 : out_index + IDX_W'(1);
    if (pop) rd_ptr_d = ~rd_ptr_q;
    occ_rem  = pop ? occ_q - 2'd1 : occ_q;
    occ_d    = cap ? occ_rem + 2'd1 : occ_rem;
    // An empty buffer after the pop means a capture this cycle is the new head.
    head_vec = (occ_rem == 2'd0) ? in_data : slot_q[rd_ptr_d];
    nsel     = neuron_of(beat_d);
    data_d   = head_vec[int'(nsel)*DATA_WIDTH +: DATA_WIDTH];
    case (state_q)
      IDLE:    if (cap) state_d = STREAM;
      STREAM:  if (pop && occ_d == 2'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      occ_q     <= 2'd0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      occ_q     <= occ_d;
      rd_ptr_q  <= rd_ptr_d;
      if (cap) wr_ptr_q <= ~wr_ptr_q;
      in_ready  <= (occ_d != 2'd2);
      out_valid <= (state_d == STREAM);
      out_data  <= (state_d == STREAM) ? data_d : '0;
      out_index <= beat_d;
      out_last  <= (state_d == STREAM) && (beat_d == LAST_IDX);
      if (drop) overflow <= 1'b1;
    end
  end

  // Vector storage carries no reset; occupancy alone marks slots valid.
  always_ff @(posedge s_axi_aclk) begin
    if (cap) slot_q[wr_ptr_q] <= in_data;
  end

  assign cur_neuron = neuron_of(out_index);

  generate
    if (EN_ARGMAX) begin : g_argmax
      layer_stream_serializer_argmax #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
      ) u_argmax (
        .s_axi_aclk (s_axi_aclk),
        .reset      (reset),
        .beat_valid (adv),
        .beat_data  (out_data),
        .beat_index (cur_neuron),
        .beat_last  (out_last),
        .max_valid  (max_valid),
        .max_index  (max_index)
      );
    end else begin : g_no_argmax
      assign max_valid = 1'b0;
      assign max_index = '0;
    end
  endgenerate

endmodule

// File: tb/tb_layer_stream_serializer.sv
// Directed bench for layer_stream_serializer: an LSB-first and an MSB-first
// instance share stimulus, NUM_NEURONS=4, DATA_WIDTH=16.
module tb_layer_stream_serializer;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = 2;

  logic            s_axi_aclk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic [N*DW-1:0] in_data;
  logic            out_ready;

  logic            in_ready, out_valid, out_last, max_valid, overflow;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_index, max_index;
  logic            m_in_ready, m_out_valid, m_out_last, m_max_valid, m_overflow;
  logic [DW-1:0]   m_out_data;
  logic [IW-1:0]   m_out_index, m_max_index;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 s_axi_aclk = ~s_axi_aclk;

  layer_stream_serializer #(.NUM_NEURONS(N), .DATA_WIDTH(DW), .MSB_FIRST(1'b0), .EN_ARGMAX(1'b1)) dut (
    .s_axi_aclk(s_axi_aclk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .max_valid(max_valid), .max_index(max_index),
    .overflow(overflow));

  layer_stream_serializer #(.NUM_NEURONS(N), .DATA_WIDTH(DW), .MSB_FIRST(1'b1), .EN_ARGMAX(1'b1)) dut_m (
    .s_axi_aclk(s_axi_aclk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(m_in_ready), .out_valid(m_out_valid), .out_ready(out_ready), .out_data(m_out_data),
    .out_index(m_out_index), .out_last(m_out_last), .max_valid(m_max_valid), .max_index(m_max_index),
    .overflow(m_overflow));

  function automatic logic [N*DW-1:0] pk(input logic [DW-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [DW-1:0] nth(input logic [N*DW-1:0] v, input int k);
    return v[k*DW +: DW];
  endfunction

  task automatic step();
    @(posedge s_axi_aclk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    n_tests++;
    if ({in_ready, out_valid, out_last, out_data, out_index, max_valid, max_index, overflow} !==
        {1'b1, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: rdy=%b ov=%b last=%b data=%h idx=%0d mv=%b mi=%0d ovf=%b want 1 0 0 0000 0 0 0 0",
               in_ready, out_valid, out_last, out_data, out_index, max_valid, max_index, overflow);
    end
  endtask

  task automatic test_basic_and_msb();
    logic [N*DW-1:0] v;
    logic [DW-1:0] exp_l, exp_m;
    v = pk(16'd3, 16'hFFFE, 16'd7, 16'd1);
    out_ready = 1'b1; in_valid = 1'b1; in_data = v;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_l = nth(v, k);
      exp_m = nth(v, 3 - k);
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== exp_l || out_index !== IW'(k) || out_last !== (k == 3)) begin
        n_fail++;
        $display("FAIL basic_beat%0d: v=%b d=%h i=%0d l=%b want 1 %h %0d %b",
                 k, out_valid, out_data, out_index, out_last, exp_l, k, k == 3);
      end
      n_tests++;
      if (m_out_valid !== 1'b1 || m_out_data !== exp_m || m_out_index !== IW'(k)) begin
        n_fail++;
        $display("FAIL msb_beat%0d: v=%b d=%h i=%0d want 1 %h %0d", k, m_out_valid, m_out_data, m_out_index, exp_m, k);
      end
      n_tests++;
      if (max_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_early_max%0d: max_valid=%b want 0", k, max_valid);
      end
      step();
    end
    n_tests++;
    if (max_valid !== 1'b1 || max_index !== 2'd2 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_max: mv=%b mi=%0d ov=%b ovf=%b want 1 2 0 0", max_valid, max_index, out_valid, overflow);
    end
    n_tests++;
    if (m_max_valid !== 1'b1 || m_max_index !== 2'd2) begin
      n_fail++;
      $display("FAIL msb_max: mv=%b mi=%0d want 1 2", m_max_valid, m_max_index);
    end
    step();
    n_tests++;
    if (max_valid !== 1'b0 || max_index !== 2'd2) begin
      n_fail++;
      $display("FAIL max_hold: mv=%b mi=%0d want 0 2", max_valid, max_index);
    end
  endtask

  task automatic test_stall();
    logic [N*DW-1:0] v;
    logic [3:0] pat;
    int k;
    v = pk(16'd10, 16'd20, 16'd30, 16'd40);
    pat = 4'b1001;
    k = 0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = v;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_index !== IW'(k) || out_data !== nth(v, k)) begin
        n_fail++;
        $display("FAIL stall_c%0d: v=%b i=%0d d=%h want 1 %0d %h", c, out_valid, out_index, out_data, k, nth(v, k));
      end
      out_ready = pat[c % 4];
      step();
      if (pat[c % 4]) k++;
    end
    out_ready = 1'b1;
    n_tests++;
    if (k != 4 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_end: beats=%0d out_valid=%b want 4 0", k, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [N*DW-1:0] v1, v2;
    v1 = pk(16'd11, 16'd12, 16'd13, 16'd14);
    v2 = pk(16'd21, 16'd22, 16'd23, 16'd24);
    out_ready = 1'b1; in_valid = 1'b1; in_data = v1;
    step();
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_index !== IW'(k) || out_data !== nth(v1, k)) begin
        n_fail++;
        $display("FAIL b2b_v1_%0d: v=%b i=%0d d=%h want 1 %0d %h", k, out_valid, out_index, out_data, k, nth(v1, k));
      end
      in_valid = (k == 3);
      in_data  = v2;
      step();
    end
    in_valid = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: in_ready=%b want 1", in_ready);
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_index !== IW'(k) || out_data !== nth(v2, k)) begin
        n_fail++;
        $display("FAIL b2b_v2_%0d: v=%b i=%0d d=%h want 1 %0d %h", k, out_valid, out_index, out_data, k, nth(v2, k));
      end
      step();
    end
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    logic [N*DW-1:0] va, vb, vc;
    va = pk(16'd1, 16'd9, 16'd2, 16'd9);
    vb = pk(16'hFFF0, 16'hFFF1, 16'hFFF2, 16'hFFF3);
    vc = pk(16'd100, 16'd101, 16'd102, 16'd103);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = va; step();
    in_data = vb; step();
    in_data = vc; step();
    in_valid = 1'b0;
    n_tests++;
    if (overflow !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== nth(va, 0)) begin
      n_fail++;
      $display("FAIL ovf_state: ovf=%b rdy=%b ov=%b d=%h want 1 0 1 %h", overflow, in_ready, out_valid, out_data, nth(va, 0));
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_index !== IW'(k % 4) ||
          out_data !== ((k < 4) ? nth(va, k) : nth(vb, k - 4))) begin
        n_fail++;
        $display("FAIL ovf_beat%0d: v=%b i=%0d d=%h want 1 %0d %h", k, out_valid, out_index, out_data, k % 4,
                 (k < 4) ? nth(va, k) : nth(vb, k - 4));
      end
      if (k == 4) begin
        n_tests++;
        if (max_valid !== 1'b1 || max_index !== 2'd1) begin
          n_fail++;
          $display("FAIL ovf_max_a: mv=%b mi=%0d want 1 1", max_valid, max_index);
        end
      end
      step();
    end
    n_tests++;
    if (out_valid !== 1'b0 || overflow !== 1'b1 || max_index !== 2'd3) begin
      n_fail++;
      $display("FAIL ovf_end: ov=%b ovf=%b mi=%0d want 0 1 3", out_valid, overflow, max_index);
    end
  endtask

  task automatic test_reset_midstream();
    logic [N*DW-1:0] v;
    out_ready = 1'b1; in_valid = 1'b1; in_data = pk(16'd4, 16'd3, 16'd2, 16'd1);
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    n_tests++;
    if (out_valid !== 1'b0 || out_index !== 2'd0 || in_ready !== 1'b1 || overflow !== 1'b0 || max_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst: ov=%b i=%0d rdy=%b ovf=%b mv=%b want 0 0 1 0 0", out_valid, out_index, in_ready, overflow, max_valid);
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      n_tests++;
      if (max_valid !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_quiet%0d: mv=%b ov=%b want 0 0", c, max_valid, out_valid);
      end
    end
    v = pk(16'd5, 16'd5, 16'd0, 16'd0);
    in_valid = 1'b1; in_data = v;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    n_tests++;
    if (max_valid !== 1'b1 || max_index !== 2'd0) begin
      n_fail++;
      $display("FAIL tie_max: mv=%b mi=%0d want 1 0", max_valid, max_index);
    end
    n_tests++;
    if (m_max_valid !== 1'b1 || m_max_index !== 2'd1) begin
      n_fail++;
      $display("FAIL tie_max_msb: mv=%b mi=%0d want 1 1", m_max_valid, m_max_index);
    end
  endtask

  initial begin
    test_reset();
    test_basic_and_msb();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
